// File: rtl/avb_arb_pkg.sv
// Shared types and constants for the Avalon bridge arbiter.
package avb_arb_pkg;

    // FSM states. The issue step is folded into IDLE, so BUSY is the
    // first cycle the request is on the bridge.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/rr_pick.sv
// Request picker: round-robin starting after the last grant, or fixed
// priority with the lowest index winning. Purely combinational.
module rr_pick
    import avb_arb_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int GID_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [GID_W-1:0]  last,
    input  logic              fixed,
    output logic [NUM_CH-1:0] gnt,
    output logic [GID_W-1:0]  gnt_id
);

    // Walk the candidates in priority order and keep the first requester.
    always_comb begin
        logic             found;
        logic [GID_W-1:0] idx;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = fixed ? GID_W'(i) : GID_W'((int'(last) + 1 + i) % NUM_CH);
            if (req[idx] && !found) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/avalon_bridge_arbiter.sv
// N-client arbiter in front of the SoC Avalon bridge port. One transfer in
// flight; bridge outputs are held until acknowledge or timeout.
module avalon_bridge_arbiter
    import avb_arb_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 16,
    parameter int BE_W        = DATA_W / 8,
    parameter int PRIO_MODE   = PRIO_RR,
    parameter int TIMEOUT_CYC = 1024,
    localparam int GID_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*BE_W-1:0]   ch_be,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic                     ch_err,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic [GID_W-1:0]         grant_id,
    output logic                     busy,
    output logic [ADDR_W-1:0]        avalon_bridge_address,
    output logic [BE_W-1:0]          avalon_bridge_byte_enable,
    output logic                     avalon_bridge_read,
    output logic                     avalon_bridge_write,
    output logic [DATA_W-1:0]        avalon_bridge_write_data,
    input  logic                     avalon_bridge_acknowledge,
    input  logic [DATA_W-1:0]        avalon_bridge_read_data
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit TO_EN = (TIMEOUT_CYC != 0);

    arb_state_e        state;
    logic [GID_W-1:0]  rr_ptr;
    logic [NUM_CH-1:0] cur_gnt;
    logic              cur_we;
    logic [TW-1:0]     to_cnt;
    logic [NUM_CH-1:0] pick_gnt;
    logic [GID_W-1:0]  pick_id;
    logic              to_hit;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .GID_W  (GID_W)
    ) u_pick (
        .req    (ch_req),
        .last   (rr_ptr),
        .fixed  (PRIO_MODE == PRIO_FIXED),
        .gnt    (pick_gnt),
        .gnt_id (pick_id)
    );

    assign to_hit = TO_EN && (to_cnt == TO_LAST);

    // Arbitration FSM with all client and bridge outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                     <= ST_IDLE;
            rr_ptr                    <= GID_W'(NUM_CH - 1);
            cur_gnt                   <= '0;
            cur_we                    <= 1'b0;
            to_cnt                    <= '0;
            ch_ack                    <= '0;
            ch_err                    <= 1'b0;
            ch_rdata                  <= '0;
            grant_id                  <= '0;
            busy                      <= 1'b0;
            avalon_bridge_address     <= '0;
            avalon_bridge_byte_enable <= '0;
            avalon_bridge_read        <= 1'b0;
            avalon_bridge_write       <= 1'b0;
            avalon_bridge_write_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|ch_req) begin
                        grant_id                  <= pick_id;
                        rr_ptr                    <= pick_id;
                        cur_gnt                   <= pick_gnt;
                        cur_we                    <= ch_we[pick_id];
                        avalon_bridge_address     <= ch_addr[int'(pick_id)*ADDR_W +: ADDR_W];
                        avalon_bridge_byte_enable <= ch_be[int'(pick_id)*BE_W +: BE_W];
                        avalon_bridge_write_data  <= ch_wdata[int'(pick_id)*DATA_W +: DATA_W];
                        avalon_bridge_read        <= !ch_we[pick_id];
                        avalon_bridge_write       <= ch_we[pick_id];
                        to_cnt                    <= '0;
                        busy                      <= 1'b1;
                        state                     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Acknowledge takes precedence over a coincident timeout.
                    if (avalon_bridge_acknowledge) begin
                        avalon_bridge_read  <= 1'b0;
                        avalon_bridge_write <= 1'b0;
                        ch_rdata            <= cur_we ? '0 : avalon_bridge_read_data;
                        ch_ack              <= cur_gnt;
                        ch_err              <= 1'b0;
                        state               <= ST_DONE;
                    end else if (to_hit) begin
                        avalon_bridge_read  <= 1'b0;
                        avalon_bridge_write <= 1'b0;
                        ch_rdata            <= '0;
                        ch_ack              <= cur_gnt;
                        ch_err              <= 1'b1;
                        state               <= ST_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    ch_ack <= '0;
                    ch_err <= 1'b0;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_bridge_arbiter.sv
// Directed bench: a round-robin instance (timeout 16) and a fixed-priority
// instance share all inputs; single-client transfers come from a vector table.
module tb_avalon_bridge_arbiter;

    localparam int N  = 3;
    localparam int AW = 26;
    localparam int DW = 16;
    localparam int BW = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    ch_req = '0;
    logic [N-1:0]    ch_we = '0;
    logic [N*AW-1:0] ch_addr = '0;
    logic [N*BW-1:0] ch_be = '0;
    logic [N*DW-1:0] ch_wdata = '0;
    logic            br_ack = 1'b0;
    logic [DW-1:0]   br_rdata = '0;

    logic [N-1:0]  rr_ack, fx_ack;
    logic          rr_err, fx_err;
    logic [DW-1:0] rr_rdata, fx_rdata;
    logic [1:0]    rr_gid, fx_gid;
    logic          rr_busy, fx_busy;
    logic [AW-1:0] rr_addr, fx_addr;
    logic [BW-1:0] rr_be, fx_be;
    logic          rr_rd, fx_rd, rr_wr, fx_wr;
    logic [DW-1:0] rr_wd, fx_wd;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    avalon_bridge_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0), .TIMEOUT_CYC(16)) u_rr (
        .clk(clk), .reset(reset), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
        .ch_be(ch_be), .ch_wdata(ch_wdata), .ch_ack(rr_ack), .ch_err(rr_err),
        .ch_rdata(rr_rdata), .grant_id(rr_gid), .busy(rr_busy),
        .avalon_bridge_address(rr_addr), .avalon_bridge_byte_enable(rr_be),
        .avalon_bridge_read(rr_rd), .avalon_bridge_write(rr_wr),
        .avalon_bridge_write_data(rr_wd), .avalon_bridge_acknowledge(br_ack),
        .avalon_bridge_read_data(br_rdata));

    avalon_bridge_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1), .TIMEOUT_CYC(16)) u_fx (
        .clk(clk), .reset(reset), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
        .ch_be(ch_be), .ch_wdata(ch_wdata), .ch_ack(fx_ack), .ch_err(fx_err),
        .ch_rdata(fx_rdata), .grant_id(fx_gid), .busy(fx_busy),
        .avalon_bridge_address(fx_addr), .avalon_bridge_byte_enable(fx_be),
        .avalon_bridge_read(fx_rd), .avalon_bridge_write(fx_wr),
        .avalon_bridge_write_data(fx_wd), .avalon_bridge_acknowledge(br_ack),
        .avalon_bridge_read_data(br_rdata));

    typedef struct {
        int            ch;
        bit            we;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
        int            lat;       // 0 = bridge never acknowledges
        logic [DW-1:0] rdata;     // bridge read data on acknowledge
        logic [DW-1:0] exp_rdata;
        bit            exp_err;
        int            exp_hi;    // cycles read/write stays high
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // One single-client transfer from the table, checked on the RR instance.
    task automatic run_vec(input vec_t v);
        int  hi;
        bit  ok;
        bit  done;
        logic [N-1:0] e_ack;
        e_ack = N'(1 << v.ch);
        ch_req = '0;
        ch_req[v.ch] = 1'b1;
        ch_we[v.ch] = v.we;
        ch_addr[v.ch*AW +: AW] = v.addr;
        ch_be[v.ch*BW +: BW] = v.be;
        ch_wdata[v.ch*DW +: DW] = v.wdata;
        hi = 0;
        ok = 1'b1;
        done = 1'b0;
        step();
        for (int n = 1; n <= 40 && !done; n++) begin
            if (rr_ack != '0) begin
                done = 1'b1;
            end else begin
                if (rr_rd || rr_wr) hi++;
                if (rr_rd !== !v.we || rr_wr !== v.we || rr_addr !== v.addr ||
                    rr_be !== v.be || rr_wd !== v.wdata || rr_gid !== 2'(v.ch))
                    ok = 1'b0;
                if (n == v.lat) begin
                    br_ack = 1'b1;
                    br_rdata = v.rdata;
                end
                step();
                br_ack = 1'b0;
                br_rdata = 16'hDEAD;
            end
        end
        chk("xfer_done", 32'(done), 32'd1);
        chk("bus_stable", 32'(ok), 32'd1);
        chk("hi_cycles", 32'(hi), 32'(v.exp_hi));
        chk("ch_ack", 32'(rr_ack), 32'(e_ack));
        chk("ch_err", 32'(rr_err), 32'(v.exp_err));
        chk("ch_rdata", 32'(rr_rdata), 32'(v.exp_rdata));
        chk("rd_dropped", 32'({rr_rd, rr_wr}), 32'd0);
        ch_req = '0;
        step();
        chk("ack_one_cycle", 32'(rr_ack), 32'd0);
        chk("idle_busy", 32'(rr_busy), 32'd0);
    endtask

    initial begin
        int last_cyc;
        vt[0] = '{ch: 1, we: 1'b0, addr: 26'h0001234, be: 2'b11, wdata: 16'h1111, lat: 3,
                  rdata: 16'hBEEF, exp_rdata: 16'hBEEF, exp_err: 1'b0, exp_hi: 3};
        vt[1] = '{ch: 2, we: 1'b1, addr: 26'h3FFFFFF, be: 2'b10, wdata: 16'hA55A, lat: 5,
                  rdata: 16'h7777, exp_rdata: 16'h0000, exp_err: 1'b0, exp_hi: 5};
        vt[2] = '{ch: 0, we: 1'b0, addr: 26'h0000000, be: 2'b00, wdata: 16'h0000, lat: 1,
                  rdata: 16'h1234, exp_rdata: 16'h1234, exp_err: 1'b0, exp_hi: 1};
        vt[3] = '{ch: 1, we: 1'b0, addr: 26'h2AAAAAA, be: 2'b01, wdata: 16'h5555, lat: 0,
                  rdata: 16'h9999, exp_rdata: 16'h0000, exp_err: 1'b1, exp_hi: 16};
        vt[4] = '{ch: 0, we: 1'b1, addr: 26'h1555555, be: 2'b11, wdata: 16'hC3C3, lat: 2,
                  rdata: 16'h8888, exp_rdata: 16'h0000, exp_err: 1'b0, exp_hi: 2};

        do_reset();
        chk("rst_ack", 32'({rr_ack, fx_ack}), 32'd0);
        chk("rst_flags", 32'({rr_err, rr_busy, rr_rd, rr_wr}), 32'd0);
        chk("rst_gid", 32'(rr_gid), 32'd0);
        chk("rst_addr", 32'(rr_addr), 32'd0);
        chk("rst_rdata", 32'(rr_rdata), 32'd0);

        // Acknowledge while idle must be ignored.
        br_ack = 1'b1;
        br_rdata = 16'hFFFF;
        step();
        br_ack = 1'b0;
        step();
        chk("stray_ack", 32'({rr_ack, rr_busy, rr_rdata}), 32'd0);

        for (int i = 0; i < 5; i++) run_vec(vt[i]);

        // Three clients requesting continuously, bridge latency 1.
        do_reset();
        ch_we = '0;
        ch_req = '1;
        last_cyc = 0;
        for (int t = 0; t < 6; t++) begin
            step();
            chk("arb_rr_gid", 32'(rr_gid), 32'(t % 3));
            chk("arb_fx_gid", 32'(fx_gid), 32'd0);
            br_ack = 1'b1;
            br_rdata = 16'(t + 16'h40);
            step();
            br_ack = 1'b0;
            chk("arb_rr_ack", 32'(rr_ack), 32'(1 << (t % 3)));
            chk("arb_fx_ack", 32'(fx_ack), 32'd1);
            chk("arb_rdata", 32'(rr_rdata), 32'(t + 16'h40));
            if (t > 0) chk("arb_period", 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
            if (t == 5) ch_req = '0;
            step();
            chk("arb_gap", 32'({rr_rd, rr_wr, fx_rd, fx_wr}), 32'd0);
        end
        step();

        // Reset in the second BUSY cycle aborts with no acknowledge.
        do_reset();
        ch_we = '0;
        ch_addr[1*AW +: AW] = 26'h0000ABC;
        ch_addr[0*AW +: AW] = 26'h0000123;
        ch_req = 3'b010;
        step();
        chk("rstmid_rd1", 32'(rr_rd), 32'd1);
        step();
        reset = 1'b1;
        step();
        chk("rstmid_out", 32'({rr_ack, rr_rd, rr_wr, rr_busy}), 32'd0);
        reset = 1'b0;
        ch_req = 3'b011;
        step();
        chk("rstmid_gid", 32'(rr_gid), 32'd0);
        chk("rstmid_addr", 32'(rr_addr), 32'h123);
        br_ack = 1'b1;
        br_rdata = 16'h0F0F;
        step();
        br_ack = 1'b0;
        ch_req = '0;
        chk("rstmid_ack", 32'(rr_ack), 32'd1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
